hex_display_ctrl: RTL
=====================

# hex_display_ctrl

Avalon-MM slave that drives up to eight active-low seven-segment digits from a register bank. It is the parametrised successor to the fixed per-digit PIO hex outputs in the Nios II system and sits as a single Qsys component between the system interconnect and the board HEX pins. Beyond plain nibble-to-segment display it adds:
- per-digit enable
- per-digit raw-segment override
- per-digit blinking from a programmable blink timer

## Interface
Parameters:
- NUM_DIGITS, 8: number of implemented digits, legal range 1..8.
- BLINK_DIV_W, 26: width of the blink counter and BLINK_PERIOD register.
- BLINK_RESET, 25000000: reset value of BLINK_PERIOD, in clocks; must fit in BLINK_DIV_W bits.

Ports:
- clk_clk  in  1  system clock; all logic is on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  3  word address of the register.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, with a fixed read latency of 1.
- hex_export  out  7*NUM_DIGITS  segment outputs, active-low. Digit i is on bits [7i+6:7i]; bit 0 is segment a and bit 6 is segment g.

## Operation
Registers (word address):
- 0 VALUE: nibble i ([4i+3:4i]) is the hex value shown on digit i. Reset value is 0.
- 1 ENABLE: bit i enables digit i. A disabled digit outputs 7'h7F. Reset value is all ones for implemented digits.
- 2 BLINK_MASK: bit i makes digit i blink. Reset value is 0.
- 3 BLINK_PERIOD: [BLINK_DIV_W-1:0] is the blink half-period in clocks. Reset value is BLINK_RESET. A write also clears the blink counter; the blink phase is kept.
- 4 RAW_SEL: bit i makes digit i show its raw segment pattern instead of the decoded nibble. Reset value is 0.
- 5 RAW_LO: raw patterns for digits 0..3, in [6:0], [14:8], [22:16], [30:24]. Reset value is 7'h7F per digit.
- 6 RAW_HI: raw patterns for digits 4..7, same byte-lane layout. Reset value is 7'h7F per digit.
- 7 STATUS: a read returns blink phase in bit 0; other bits read 0. Any write clears both the blink counter and the blink phase.

Access rules:
- Bits belonging to digits at or above NUM_DIGITS, and all unused bits, read as 0 and ignore writes.
- The slave has no byte enables; every write updates the whole register.

Decode, active-low:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Per-digit output, in priority order:
1. ENABLE[i]=0 → 7'h7F.
2. Otherwise, BLINK_MASK[i]=1 and phase=1 → 7'h7F.
3. Otherwise, RAW_SEL[i]=1 → the digit's raw pattern.
4. Otherwise → decode of VALUE nibble i.

Blink timer:
- When BLINK_PERIOD is 0, the counter and phase are held at 0, so blinking digits stay visible.
- Otherwise the counter increments every clock. When it equals BLINK_PERIOD-1, it wraps to 0 and phase toggles.
- A write to BLINK_PERIOD with a value at or below the current count takes effect immediately, because the counter is cleared by the write.

## Timing
- Asynchronous reset asserted: all registers, the counter and phase go to their reset values, and hex_export goes to all ones (blank) immediately. avs_readdata resets to 0.
- The first rising edge after reset release loads hex_export with the reset-state display, which is "0" on every digit.
- Write latency: a register is updated at the edge that samples avs_write. hex_export reflects the change at the next edge (2 edges from the strobe).
- Read latency: avs_readdata is valid on the cycle after avs_read. It holds its value when no read is issued. The slave has no waitrequest.
- Simultaneous avs_read and avs_write: the write is performed, and readdata returns the pre-write value.
- Blink phase toggle to hex_export change: 1 cycle.
- Reset asserted mid-write: the write is lost and the register takes its reset value.

## Test plan
- Reset, then release; wait 2 cycles → hex_export = {8{7'h40}}. Read ENABLE → 32'h000000FF.
- Write VALUE=32'hFEDCBA98 → two edges later, digits 0..7 show 00,10,08,03,46,21,06,0E. Readback returns 32'hFEDCBA98.
- Write RAW_LO=32'h00000036 and RAW_SEL=32'h1 → digit 0 = 7'h36. Then write ENABLE=32'hFE → digit 0 = 7'h7F, since disable overrides raw. The other digits are unchanged.
- Write BLINK_PERIOD=4, then BLINK_MASK=32'h02 → digit 1 alternates visible/blank every 4 clocks. STATUS bit 0 matches. A STATUS write forces phase 0 and digit 1 visible on the next edge.
- Write BLINK_PERIOD=0 while phase=1 → phase reads 0 and the blinking digit stays visible indefinitely.
- NUM_DIGITS=3 build: write VALUE=32'hFFFFFFFF → readback is 32'h00000FFF, and hex_export is 21 bits wide showing 0E,0E,0E.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Avalon-MM register bank driving up to eight active-low seven-segment digits.
// Latency: register write to hex_export 2 edges; read data 1 cycle after avs_read.
// Backpressure: none; no waitrequest, every access completes in a single cycle.
module hex_display_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int BLINK_DIV_W = 26,
  parameter int BLINK_RESET = 25000000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [2:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_export
);

  // Register word addresses.
  localparam logic [2:0] ADDR_VALUE   = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_BMASK   = 3'd2;
  localparam logic [2:0] ADDR_PERIOD  = 3'd3;
  localparam logic [2:0] ADDR_RAW_SEL = 3'd4;
  localparam logic [2:0] ADDR_RAW_LO  = 3'd5;
  localparam logic [2:0] ADDR_RAW_HI  = 3'd6;
  localparam logic [2:0] ADDR_STATUS  = 3'd7;

  // One bit per implemented digit.
  function automatic logic [7:0] dig_mask_f();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < NUM_DIGITS) m[i] = 1'b1;
    end
    return m;
  endfunction

  // One nibble per implemented digit.
  function automatic logic [31:0] value_mask_f();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < NUM_DIGITS) m[4*i +: 4] = 4'hF;
    end
    return m;
  endfunction

  // Seven-bit byte lanes of implemented digits, starting at digit 'base'.
  function automatic logic [31:0] raw_mask_f(input int base);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (base + i < NUM_DIGITS) m[8*i +: 7] = 7'h7F;
    end
    return m;
  endfunction

  // Hex nibble to active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  localparam logic [7:0]             DIG_MASK    = dig_mask_f();
  localparam logic [31:0]            VALUE_MASK  = value_mask_f();
  localparam logic [31:0]            RAW_LO_MASK = raw_mask_f(0);
  localparam logic [31:0]            RAW_HI_MASK = raw_mask_f(4);
  localparam logic [BLINK_DIV_W-1:0] PERIOD_RST  = BLINK_DIV_W'(BLINK_RESET);
  localparam logic [BLINK_DIV_W-1:0] CNT_ONE     = BLINK_DIV_W'(1);

  logic [31:0]             value_q,    value_d;
  logic [7:0]              enable_q,   enable_d;
  logic [7:0]              bmask_q,    bmask_d;
  logic [BLINK_DIV_W-1:0]  period_q,   period_d;
  logic [7:0]              raw_sel_q,  raw_sel_d;
  logic [31:0]             raw_lo_q,   raw_lo_d;
  logic [31:0]             raw_hi_q,   raw_hi_d;
  logic [BLINK_DIV_W-1:0]  cnt_q,      cnt_d;
  logic                    phase_q,    phase_d;
  logic [31:0]             readdata_q, readdata_d;
  logic [7*NUM_DIGITS-1:0] hex_q,      hex_d;
  logic [31:0]             rd_mux;
  logic [63:0]             raw_all;

  logic wr_period, wr_status;
  assign wr_period = avs_write && (avs_address == ADDR_PERIOD);
  assign wr_status = avs_write && (avs_address == ADDR_STATUS);

  // Register writes: whole-word, with unimplemented bits forced to zero.
  always_comb begin
    value_d   = value_q;
    enable_d  = enable_q;
    bmask_d   = bmask_q;
    period_d  = period_q;
    raw_sel_d = raw_sel_q;
    raw_lo_d  = raw_lo_q;
    raw_hi_d  = raw_hi_q;
    if (avs_write) begin
      case (avs_address)
        ADDR_VALUE:   value_d   = avs_writedata & VALUE_MASK;
        ADDR_ENABLE:  enable_d  = avs_writedata[7:0] & DIG_MASK;
        ADDR_BMASK:   bmask_d   = avs_writedata[7:0] & DIG_MASK;
        ADDR_PERIOD:  period_d  = avs_writedata[BLINK_DIV_W-1:0];
        ADDR_RAW_SEL: raw_sel_d = avs_writedata[7:0] & DIG_MASK;
        ADDR_RAW_LO:  raw_lo_d  = avs_writedata & RAW_LO_MASK;
        ADDR_RAW_HI:  raw_hi_d  = avs_writedata & RAW_HI_MASK;
        default: ;
      endcase
    end
  end

  // Blink timer: bus writes take priority over counting; period 0 parks at phase 0.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_status) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wr_period) begin
      cnt_d   = '0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period_q - CNT_ONE) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_ONE;
    end
  end

  // Read mux from current (pre-write) state; readdata holds between reads.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_VALUE:   rd_mux = value_q;
      ADDR_ENABLE:  rd_mux = {24'b0, enable_q};
      ADDR_BMASK:   rd_mux = {24'b0, bmask_q};
      ADDR_PERIOD:  rd_mux = 32'(period_q);
      ADDR_RAW_SEL: rd_mux = {24'b0, raw_sel_q};
      ADDR_RAW_LO:  rd_mux = raw_lo_q;
      ADDR_RAW_HI:  rd_mux = raw_hi_q;
      default:      rd_mux = {31'b0, phase_q};
    endcase
    readdata_d = avs_read ? rd_mux : readdata_q;
  end

  assign raw_all = {raw_hi_q, raw_lo_q};

  // Per-digit output select: disable, then blink blanking, then raw, then decode.
  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!enable_q[i]) begin
        hex_d[7*i +: 7] = 7'h7F;
      end else if (bmask_q[i] && phase_q) begin
        hex_d[7*i +: 7] = 7'h7F;
      end else if (raw_sel_q[i]) begin
        hex_d[7*i +: 7] = raw_all[8*i +: 7];
      end else begin
        hex_d[7*i +: 7] = seg_decode(value_q[4*i +: 4]);
      end
    end
  end

  // State registers; outputs blank and registers take reset values asynchronously.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      value_q    <= '0;
      enable_q   <= DIG_MASK;
      bmask_q    <= '0;
      period_q   <= PERIOD_RST;
      raw_sel_q  <= '0;
      raw_lo_q   <= RAW_LO_MASK;
      raw_hi_q   <= RAW_HI_MASK;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
      hex_q      <= '1;
    end else begin
      value_q    <= value_d;
      enable_q   <= enable_d;
      bmask_q    <= bmask_d;
      period_q   <= period_d;
      raw_sel_q  <= raw_sel_d;
      raw_lo_q   <= raw_lo_d;
      raw_hi_q   <= raw_hi_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
      hex_q      <= hex_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign hex_export   = hex_q;

endmodule
